mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: cycles from mem_addr valid to mem_rdata valid, legal range 1..15.
REQ-002 SHALL have parameter WR_LAT, default 1: cycles mem_wr is held per write, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port req, input, 1: access request from the control unit, sampled only in IDLE.
REQ-006 SHALL have port we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port dst, input, 1: read destination, 0 = IR, 1 = MDR.
REQ-008 SHALL have port addr, input, 32: byte address.
REQ-009 SHALL have port wdata, input, 32: store data.
REQ-010 SHALL have port mem_rdata, input, 32: memory read data.
REQ-011 SHALL have port mem_addr, output, 32: latched access address.
REQ-012 SHALL have port mem_wr, output, 1: memory write strobe.
REQ-013 SHALL have port mem_wdata, output, 32: latched store data.
REQ-014 SHALL have port busy, output, 1: high in READ, WRITE and DONE.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port misaligned, output, 1: one-cycle error pulse.
REQ-017 SHALL have port ir, output, 32: instruction register.
REQ-018 SHALL have port mdr, output, 32: memory data register.
REQ-019 SHALL have port opcode, output, 6: ir[31:26].
REQ-020 SHALL have port funct, output, 6: ir[5:0].

Function
REQ-021 SHALL implement FSM states IDLE, READ, WRITE, DONE, ERR.
REQ-022 IDLE, req=1, addr[1:0]!=0 SHALL go to ERR with no memory access and no latch update.
REQ-023 IDLE, req=1, aligned SHALL latch addr, wdata, dst; go to WRITE if we=1, else READ; load counter with RD_LAT or WR_LAT.
REQ-024 READ SHALL hold mem_wr=0 and decrement the counter each cycle; at counter=1, SHALL capture mem_rdata into ir (dst=0) or mdr (dst=1) and go to DONE.
REQ-025 WRITE SHALL drive mem_wr=1 and decrement the counter; at counter=1, SHALL go to DONE; mem_wr SHALL be 0 in every other state.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 ERR SHALL assert misaligned for exactly one cycle, then return to IDLE.
REQ-028 Read latency SHALL be: req-sample cycle N gives done in cycle N+RD_LAT+1, with the captured register valid in that same cycle.
REQ-029 Write latency SHALL be: done in cycle N+WR_LAT+1.
REQ-030 req outside IDLE SHALL be ignored; back-to-back accesses SHALL need req high in the IDLE cycle after DONE.
REQ-031 mem_addr and mem_wdata SHALL stay stable from the accept cycle until the next accepted request.
REQ-032 The register not selected by dst SHALL be unchanged; writes SHALL change neither ir nor mdr.
REQ-033 opcode and funct SHALL be combinational from ir, with no extra latency.

Reset
REQ-034 Reset SHALL asynchronously force state=IDLE, counter=0, ir=0, mdr=0, mem_addr=0, mem_wdata=0, done=0, misaligned=0, busy=0, mem_wr=0.
REQ-035 Reset mid-access SHALL abort at once: mem_wr drops in the same cycle, no capture occurs, and no done is emitted.

Structure
REQ-036 Shared package cpu_pkg SHALL hold the state enum mem_state_t, default RD_LAT/WR_LAT constants, and opcode/funct bit-position constants.
REQ-037 Block SHALL be a single module; no sub-module is required; counter width SHALL be 4 bits.

Verification
REQ-038 Read to IR: RD_LAT=2, req, we=0, dst=0, addr=0x10, mem_rdata=0x8C220004 -> done in cycle 3, ir=0x8C220004, opcode=0x23, mdr unchanged.
REQ-039 Write: WR_LAT=1, req, we=1, addr=0x20, wdata=0xDEADBEEF -> mem_wr high exactly 1 cycle with mem_addr=0x20, mem_wdata=0xDEADBEEF, done in cycle 2.
REQ-040 Misaligned: req, addr=0x13 -> misaligned pulse in cycle 1, mem_wr never high, ir and mdr unchanged, done never high.
REQ-041 Busy-ignore: req held high through a read to MDR at addr=0x4 -> exactly one done per IDLE acceptance, second access starts only after DONE.
REQ-042 Reset mid-write: WR_LAT=3, reset asserted in second WRITE cycle -> mem_wr=0 immediately, state IDLE, no done.
REQ-043 Latency sweep: RD_LAT in {1, 4, 15} -> done exactly RD_LAT+1 cycles after the accept cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-access FSM states, default latencies and IR field positions.
// Pure declarations; no logic.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } mem_state_t;

    localparam int DEF_RD_LAT = 2;
    localparam int DEF_WR_LAT = 1;
    localparam int CNT_W      = 4;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: one read (into IR or MDR) or write per accepted req; done RD_LAT+1 / WR_LAT+1 cycles after accept.
// No backpressure: req is sampled only in IDLE and ignored while busy; misaligned requests pulse misaligned instead.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        dst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dst;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_ir;
    logic [31:0]      r_mdr;
    logic             w_aligned;
    logic             w_last;

    assign w_aligned = (addr[1:0] == 2'b00);
    assign w_last    = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dst   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ir    <= '0;
            r_mdr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        if (!w_aligned) begin
                            // Misaligned: no latch update, no memory access.
                            r_state <= ST_ERR;
                        end else begin
                            r_addr  <= addr;
                            r_wdata <= wdata;
                            r_dst   <= dst;
                            if (we) begin
                                r_state <= ST_WRITE;
                                r_cnt   <= CNT_W'(WR_LAT);
                            end else begin
                                r_state <= ST_READ;
                                r_cnt   <= CNT_W'(RD_LAT);
                            end
                        end
                    end
                end
                ST_READ: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        if (r_dst) r_mdr <= mem_rdata;
                        else       r_ir  <= mem_rdata;
                        r_state <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign mem_wr     = (r_state == ST_WRITE);
    assign busy       = (r_state == ST_READ) || (r_state == ST_WRITE) || (r_state == ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign misaligned = (r_state == ST_ERR);

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign ir        = r_ir;
    assign mdr       = r_mdr;
    assign opcode    = r_ir[OPCODE_MSB:OPCODE_LSB];
    assign funct     = r_ir[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench: four instances with different latencies share one stimulus; an access-schedule model predicts every output per cycle.
module tb_mem_access_ctrl;

    localparam int NI = 4;
    localparam int RDL [NI] = '{2, 1, 4, 15};
    localparam int WRL [NI] = '{1, 3, 1, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        dst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic [31:0] o_mem_addr  [NI];
    logic        o_mem_wr    [NI];
    logic [31:0] o_mem_wdata [NI];
    logic        o_busy      [NI];
    logic        o_done      [NI];
    logic        o_mis       [NI];
    logic [31:0] o_ir        [NI];
    logic [31:0] o_mdr       [NI];
    logic [5:0]  o_opcode    [NI];
    logic [5:0]  o_funct     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_access_ctrl #(.RD_LAT(RDL[g]), .WR_LAT(WRL[g])) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req        (req),
            .we         (we),
            .dst        (dst),
            .addr       (addr),
            .wdata      (wdata),
            .mem_rdata  (mem_rdata),
            .mem_addr   (o_mem_addr[g]),
            .mem_wr     (o_mem_wr[g]),
            .mem_wdata  (o_mem_wdata[g]),
            .busy       (o_busy[g]),
            .done       (o_done[g]),
            .misaligned (o_mis[g]),
            .ir         (o_ir[g]),
            .mdr        (o_mdr[g]),
            .opcode     (o_opcode[g]),
            .funct      (o_funct[g])
        );
    end

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] m_ir    [NI];
    logic [31:0] m_mdr   [NI];
    logic [31:0] m_addr  [NI];
    logic [31:0] m_wdata [NI];

    task automatic chk(input string nm, input int i, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", nm, i, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            m_ir[i] = '0; m_mdr[i] = '0; m_addr[i] = '0; m_wdata[i] = '0;
        end
    endtask

    task automatic chk_regs(input int i);
        chk("mem_addr",  i, o_mem_addr[i],  m_addr[i]);
        chk("mem_wdata", i, o_mem_wdata[i], m_wdata[i]);
        chk("ir",        i, o_ir[i],        m_ir[i]);
        chk("mdr",       i, o_mdr[i],       m_mdr[i]);
        chk("opc_fn",    i, {o_opcode[i], o_funct[i]}, {m_ir[i][31:26], m_ir[i][5:0]});
    endtask

    // One access whose request is held for hold_len cycles; memory returns trdata+c-2 in cycle c.
    task automatic run_access(input logic twe, input logic tdst, input logic [31:0] taddr,
                              input logic [31:0] twdata, input logic [31:0] trdata, input int hold_len);
        int last_acc [NI];
        int next_free [NI];
        int kind;
        int nc;
        kind = (taddr[1:0] != 2'b00) ? 2 : (twe ? 1 : 0);
        nc = hold_len + 18;
        for (int i = 0; i < NI; i++) begin
            last_acc[i] = -1000;
            next_free[i] = 0;
        end
        for (int c = 0; c < nc; c++) begin
            @(posedge clk); #1;
            req = (c < hold_len); we = twe; dst = tdst; addr = taddr; wdata = twdata;
            mem_rdata = trdata + 32'(c) - 32'd2;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                int L;
                int d;
                logic e_busy, e_done, e_wr, e_mis;
                L = (kind == 1) ? WRL[i] : RDL[i];
                d = c - last_acc[i];
                if (kind == 2) begin
                    e_mis = (d == 1); e_busy = 1'b0; e_done = 1'b0; e_wr = 1'b0;
                end else begin
                    e_mis  = 1'b0;
                    e_busy = (d >= 1) && (d <= L + 1);
                    e_done = (d == L + 1);
                    e_wr   = (kind == 1) && (d >= 1) && (d <= L);
                end
                chk("flags", i, {o_busy[i], o_done[i], o_mem_wr[i], o_mis[i]}, {e_busy, e_done, e_wr, e_mis});
                chk_regs(i);
                if (kind == 0 && d == L) begin
                    if (tdst) m_mdr[i] = mem_rdata;
                    else      m_ir[i]  = mem_rdata;
                end
                if (req && c >= next_free[i]) begin
                    last_acc[i] = c;
                    next_free[i] = c + ((kind == 2) ? 2 : L + 2);
                    if (kind != 2) begin
                        m_addr[i] = taddr;
                        m_wdata[i] = twdata;
                    end
                end
            end
        end
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < NI; i++) begin
            chk("rst_flags", i, {o_busy[i], o_done[i], o_mem_wr[i], o_mis[i]}, 4'b0000);
            chk_regs(i);
        end
    endtask

    initial begin
        logic [31:0] r_a;
        logic [31:0] r_w;
        logic [31:0] r_d;
        logic        r_mis;
        int          hl;

        model_clear();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Read to IR, instance 0 has RD_LAT=2.
        run_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h8C220004, 1);
        chk("dir_ir", 0, o_ir[0], 32'h8C220004);
        chk("dir_opcode", 0, o_opcode[0], 6'h23);
        chk("dir_mdr", 0, o_mdr[0], 32'h0);

        // Write.
        run_access(1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1);
        chk("dir_waddr", 0, o_mem_addr[0], 32'h20);
        chk("dir_wdata", 0, o_mem_wdata[0], 32'hDEADBEEF);

        // Misaligned.
        run_access(1'b0, 1'b0, 32'h13, 32'h12345678, 32'hCAFEF00D, 1);
        chk("dir_mis_addr", 0, o_mem_addr[0], 32'h20);

        // Request held high through back-to-back reads to MDR.
        run_access(1'b0, 1'b1, 32'h4, 32'h0, 32'h55AA0000, 30);

        // Reset in the second WRITE cycle of instance 1 (WR_LAT=3).
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; dst = 1'b0; addr = 32'h40; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("mid_wr_before", 1, o_mem_wr[1], 1'b1);
        reset = 1'b1;
        #1;
        model_clear();
        for (int i = 0; i < NI; i++)
            chk("mid_wr_abort", i, {o_mem_wr[i], o_busy[i], o_done[i]}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("post_rst_flags", i, {o_busy[i], o_done[i], o_mem_wr[i], o_mis[i]}, 4'b0000);
                chk_regs(i);
            end
        end

        // Randomised accesses.
        for (int n = 0; n < 40; n++) begin
            r_a = $urandom;
            r_w = $urandom;
            r_d = $urandom;
            r_mis = ($urandom_range(0, 4) == 0);
            if (!r_mis) r_a[1:0] = 2'b00;
            else if (r_a[1:0] == 2'b00) r_a[1:0] = 2'b10;
            hl = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 25) : 1;
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_a, r_w, r_d, hl);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
